collision_checker: RTL and testbench
====================================

Name: collision_checker

Overview:
Multi-cycle collision detector that serves the game-control FSM's collision-check state. While `check` is held high, it snapshots the helicopter and three obstacle positions. It then tests one candidate per cycle (obstacles A, B, C, then screen bounds) and returns `doneCheck` plus `collision`. The FSM uses these to choose between the next frame and game over.

Parameters:
- HELI_W, 8, helicopter sprite width in pixels
- HELI_H, 6, helicopter sprite height in pixels
- OBS_W, 6, obstacle column width in pixels
- SCREEN_H, 120, visible screen height in rows
- X_W, 8, x-coordinate width
- Y_W, 7, y-coordinate width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- check  in  1  level request from the FSM; held high until `doneCheck` is seen
- heli_x  in  X_W  helicopter top-left x
- heli_y  in  Y_W  helicopter top-left y
- obsA_x, obsB_x, obsC_x  in  X_W each  obstacle left x
- obsA_y, obsB_y, obsC_y  in  Y_W each  obstacle top y
- obsA_h, obsB_h, obsC_h  in  Y_W each  obstacle height; 0 means obstacle absent
- doneCheck  out  1  result valid; high only in state DONE
- collision  out  1  OR of `hit_flags`; registered
- hit_flags  out  4  bit0 A, bit1 B, bit2 C, bit3 bounds; registered, sticky per check

Behaviour:
- Reset (synchronous, `reset`=1 at an edge):
  - state becomes IDLE.
  - `hit_flags`=0, `collision`=0, `doneCheck`=0.
  - Snapshot registers become 0.
  - Reset overrides any state, including mid-check.
- States:
  - IDLE, CMP_A, CMP_B, CMP_C, BOUNDS, DONE.
  - `doneCheck` = (state==DONE) is the only combinational decode.
- IDLE:
  - If `check`=1 at an edge: capture all position inputs into snapshot registers, clear `hit_flags`, and go to CMP_A.
  - Otherwise stay in IDLE.
- CMP_A / CMP_B / CMP_C:
  - Compare the snapshot heli rectangle against obstacle A / B / C.
  - On overlap, set the corresponding `hit_flags` bit at the exiting edge.
  - Advance to the next state.
- Overlap rule:
  - Heli rectangle spans [hx, hx+HELI_W-1] × [hy, hy+HELI_H-1].
  - Obstacle rectangle spans [ox, ox+OBS_W-1] × [oy, oy+oh-1].
  - Hit iff hx <= ox+OBS_W-1, ox <= hx+HELI_W-1, hy <= oy+oh-1, oy <= hy+HELI_H-1, and oh != 0.
  - All sums are computed at X_W+1 / Y_W+1 bits; no wrap-around is permitted.
  - Edges that touch count as a hit (inclusive bounds).
- BOUNDS:
  - Set bit3 if hy == 0 (ceiling) or hy+HELI_H > SCREEN_H (floor), using the Y_W+1-bit sum.
  - Advance to DONE.
- DONE:
  - `doneCheck`=1.
  - Stay in DONE while `check`=1; return to IDLE on the edge where `check`=0.
  - `hit_flags` and `collision` hold their values after leaving DONE until the next capture, so the game-over state can still read them.
- Latency:
  - Capture edge E0; `doneCheck` rises after E4 (4 edges later).
  - Fixed regardless of result; no early exit on the first hit.
- Abort: if `check` drops in CMP_A through BOUNDS, go to IDLE at that edge, clear `hit_flags`, and never assert `doneCheck`.
- Input changes after capture are ignored until the next IDLE capture. The FSM may move offsets during the check without corrupting the result.
- Back-to-back checks: `check` low for one cycle, then high again, starts a fresh capture from IDLE. Flags are cleared at that capture edge.
- `check` high at the same edge as `reset`: reset wins; capture happens on the first non-reset edge with `check`=1.

Test Plan:
- Reset, then `check`=1 with heli (10,50) and obstacles A/B/C at x=100,120,140 with h=20 → `doneCheck` rises 4 edges after capture; `collision`=0, `hit_flags`=0000.
- Heli (10,50), obsB (15,40,h=12): y range 40..51 overlaps 50..55 → `hit_flags`=0010, `collision`=1. Repeat with obsB_y=56 → no hit (boundary); with obsB_y=55 → hit (touching is inclusive).
- Heli_y=0 → `hit_flags`=1000. Heli_y=114 (114+6=120) → no hit. Heli_y=115 → bounds hit. Obstacle with h=0 placed exactly on the heli → no hit.
- Wrap check: heli_x=250, obsA_x=2 with no true overlap → no hit. With HELI_W=8 the 250+7 sum must not wrap to a small value.
- Abort: drop `check` in CMP_B → IDLE next edge, `doneCheck` never high, flags=0. Assert `reset` in CMP_C after an A hit → all outputs 0 next cycle.
- Inputs change in the cycle after capture → result matches the captured values. Hold `check` in DONE for 3 cycles → `doneCheck` stays high; after `check` drops, flags hold until the next capture clears them.

Source files
------------

// File: rtl/collision_checker_if.sv
// ---------------------------------------------------------------------------
// collision_checker_if
// Request/result bundle between the game-control FSM and the collision checker.
//   check                  : level request, held high until doneCheck is seen
//   heli_x / heli_y        : helicopter top-left corner
//   obs{A,B,C}_{x,y,h}     : obstacle left x, top y, height (h==0 -> absent)
//   doneCheck              : result valid
//   collision              : OR of hit_flags
//   hit_flags              : bit0 A, bit1 B, bit2 C, bit3 screen bounds
// master = FSM side, slave = checker side.
// ---------------------------------------------------------------------------
interface collision_checker_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           check;
    logic [X_W-1:0] heli_x;
    logic [Y_W-1:0] heli_y;
    logic [X_W-1:0] obsA_x, obsB_x, obsC_x;
    logic [Y_W-1:0] obsA_y, obsB_y, obsC_y;
    logic [Y_W-1:0] obsA_h, obsB_h, obsC_h;
    logic           doneCheck;
    logic           collision;
    logic [3:0]     hit_flags;

    modport master (
        output check, heli_x, heli_y,
               obsA_x, obsB_x, obsC_x,
               obsA_y, obsB_y, obsC_y,
               obsA_h, obsB_h, obsC_h,
        input  doneCheck, collision, hit_flags
    );

    modport slave (
        input  check, heli_x, heli_y,
               obsA_x, obsB_x, obsC_x,
               obsA_y, obsB_y, obsC_y,
               obsA_h, obsB_h, obsC_h,
        output doneCheck, collision, hit_flags
    );
endinterface

// File: rtl/collision_checker.sv
// ---------------------------------------------------------------------------
// collision_checker
// Multi-cycle collision detector for the game-control FSM. On a check request
// it snapshots the helicopter and three obstacle positions, then tests one
// candidate per cycle (A, B, C, screen bounds) and reports the result.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : collision_checker_if.slave (request, positions, results)
// Latency from capture edge to doneCheck is fixed at 4 edges.
// ---------------------------------------------------------------------------
module collision_checker #(
    parameter int HELI_W   = 8,
    parameter int HELI_H   = 6,
    parameter int OBS_W    = 6,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic               clock,
    input  logic               reset,
    collision_checker_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CMP_A, CMP_B, CMP_C, BOUNDS, DONE} state_t;

    state_t         state;
    logic [X_W-1:0] hx_q;
    logic [Y_W-1:0] hy_q;
    logic [X_W-1:0] ox_q [3];
    logic [Y_W-1:0] oy_q [3];
    logic [Y_W-1:0] oh_q [3];
    logic [3:0]     flags_q;
    logic           coll_q;

    // Comparison datapath, shared by the three obstacle states.
    logic [1:0]     idx;
    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y, sel_h;
    logic [X_W:0]   heli_right, obs_right;
    logic [Y_W:0]   heli_bot, obs_bot, heli_floor;
    logic           obs_hit, bounds_hit;

    always_comb begin
        idx = 2'd0;
        case (state)
            CMP_B:   idx = 2'd1;
            CMP_C:   idx = 2'd2;
            default: idx = 2'd0;
        endcase
        sel_x = ox_q[idx];
        sel_y = oy_q[idx];
        sel_h = oh_q[idx];

        // One extra bit on every sum so right/bottom edges never wrap.
        heli_right = {1'b0, hx_q} + (X_W+1)'(HELI_W - 1);
        obs_right  = {1'b0, sel_x} + (X_W+1)'(OBS_W - 1);
        heli_bot   = {1'b0, hy_q} + (Y_W+1)'(HELI_H - 1);
        // sel_h != 0 is part of the hit term, so the -1 cannot underflow when it matters.
        obs_bot    = {1'b0, sel_y} + {1'b0, sel_h} - (Y_W+1)'(1);

        obs_hit = (sel_h != '0)
               && ({1'b0, hx_q}  <= obs_right)
               && ({1'b0, sel_x} <= heli_right)
               && ({1'b0, hy_q}  <= obs_bot)
               && ({1'b0, sel_y} <= heli_bot);

        heli_floor = {1'b0, hy_q} + (Y_W+1)'(HELI_H);
        bounds_hit = (hy_q == '0) || (heli_floor > (Y_W+1)'(SCREEN_H));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            flags_q <= '0;
            coll_q  <= 1'b0;
            hx_q    <= '0;
            hy_q    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                ox_q[i] <= '0;
                oy_q[i] <= '0;
                oh_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.check) begin
                        hx_q    <= bus.heli_x;
                        hy_q    <= bus.heli_y;
                        ox_q[0] <= bus.obsA_x;
                        ox_q[1] <= bus.obsB_x;
                        ox_q[2] <= bus.obsC_x;
                        oy_q[0] <= bus.obsA_y;
                        oy_q[1] <= bus.obsB_y;
                        oy_q[2] <= bus.obsC_y;
                        oh_q[0] <= bus.obsA_h;
                        oh_q[1] <= bus.obsB_h;
                        oh_q[2] <= bus.obsC_h;
                        flags_q <= '0;
                        coll_q  <= 1'b0;
                        state   <= CMP_A;
                    end
                end
                CMP_A, CMP_B, CMP_C: begin
                    if (!bus.check) begin
                        flags_q <= '0;
                        coll_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (obs_hit) begin
                            flags_q[idx] <= 1'b1;
                            coll_q       <= 1'b1;
                        end
                        case (state)
                            CMP_A:   state <= CMP_B;
                            CMP_B:   state <= CMP_C;
                            default: state <= BOUNDS;
                        endcase
                    end
                end
                BOUNDS: begin
                    if (!bus.check) begin
                        flags_q <= '0;
                        coll_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (bounds_hit) begin
                            flags_q[3] <= 1'b1;
                            coll_q     <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Flags are left alone so they remain readable after IDLE.
                    if (!bus.check) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.doneCheck = (state == DONE);
    assign bus.collision = coll_q;
    assign bus.hit_flags = flags_q;

endmodule

// File: tb/tb_collision_checker.sv
module tb_collision_checker;
    localparam int X_W = 8;
    localparam int Y_W = 7;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    collision_checker_if #(.X_W(X_W), .Y_W(Y_W)) bus();

    collision_checker #(
        .HELI_W(8), .HELI_H(6), .OBS_W(6), .SCREEN_H(120), .X_W(X_W), .Y_W(Y_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] flags;
        logic       coll;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model in plain integers: no width limits, so no wrap.
    function automatic bit ovl(int hx, int hy, int ox, int oy, int oh);
        return (oh != 0) && (hx <= ox + 5) && (ox <= hx + 7)
            && (hy <= oy + oh - 1) && (oy <= hy + 5);
    endfunction

    function automatic bit oob(int hy);
        return (hy == 0) || (hy + 6 > 120);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_case(input bit push, input int hx, input int hy,
                              input int ax, input int ay, input int ah,
                              input int bx, input int by, input int bh,
                              input int cx, input int cy, input int ch);
        exp_t e;
        bus.heli_x = 8'(hx);  bus.heli_y = 7'(hy);
        bus.obsA_x = 8'(ax);  bus.obsA_y = 7'(ay);  bus.obsA_h = 7'(ah);
        bus.obsB_x = 8'(bx);  bus.obsB_y = 7'(by);  bus.obsB_h = 7'(bh);
        bus.obsC_x = 8'(cx);  bus.obsC_y = 7'(cy);  bus.obsC_h = 7'(ch);
        e.flags = {oob(hy), ovl(hx, hy, cx, cy, ch), ovl(hx, hy, bx, by, bh), ovl(hx, hy, ax, ay, ah)};
        e.coll  = |e.flags;
        if (push) sb.push_back(e);
    endtask

    task automatic scramble();
        bus.heli_x = 8'($urandom);  bus.heli_y = 7'($urandom);
        bus.obsA_x = 8'($urandom);  bus.obsA_y = 7'($urandom);  bus.obsA_h = 7'($urandom);
        bus.obsB_x = 8'($urandom);  bus.obsB_y = 7'($urandom);  bus.obsB_h = 7'($urandom);
        bus.obsC_x = 8'($urandom);  bus.obsC_y = 7'($urandom);  bus.obsC_h = 7'($urandom);
    endtask

    task automatic run_check(input string tag, input int hold);
        exp_t e;
        int   cyc;
        bit   seen;
        bus.check = 1'b1;
        tick();                                   // capture edge
        chk({tag, " clr"}, 32'(bus.hit_flags), 32'd0);
        chk({tag, " nodone"}, 32'(bus.doneCheck), 32'd0);
        scramble();                               // must not affect the result
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 10) begin
            tick();
            cyc++;
            if (bus.doneCheck) seen = 1;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd4);
        e = sb.pop_front();
        chk({tag, " flags"}, 32'(bus.hit_flags), 32'(e.flags));
        chk({tag, " coll"}, 32'(bus.collision), 32'(e.coll));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " hold_done"}, 32'(bus.doneCheck), 32'd1);
        end
        bus.check = 1'b0;
        tick();
        chk({tag, " done_low"}, 32'(bus.doneCheck), 32'd0);
        chk({tag, " flags_held"}, 32'(bus.hit_flags), 32'(e.flags));
        chk({tag, " coll_held"}, 32'(bus.collision), 32'(e.coll));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with check already high: reset must win.
        reset = 1'b1;
        bus.check = 1'b1;
        drive_case(1, 10, 50, 100, 40, 20, 120, 40, 20, 140, 40, 20);
        tick();
        tick();
        chk("rst done", 32'(bus.doneCheck), 32'd0);
        chk("rst flags", 32'(bus.hit_flags), 32'd0);
        chk("rst coll", 32'(bus.collision), 32'd0);
        reset = 1'b0;
        run_check("base", 0);

        drive_case(1, 10, 50, 100, 40, 20, 15, 40, 12, 140, 40, 20);
        run_check("objB", 0);
        drive_case(1, 10, 50, 100, 40, 20, 15, 56, 12, 140, 40, 20);
        run_check("objB_y56", 0);
        drive_case(1, 10, 50, 100, 40, 20, 15, 55, 12, 140, 40, 20);
        run_check("objB_y55", 0);

        drive_case(1, 10, 0, 100, 40, 20, 120, 40, 20, 140, 40, 20);
        run_check("ceil", 0);
        drive_case(1, 10, 114, 100, 40, 20, 120, 40, 20, 140, 40, 20);
        run_check("floor114", 0);
        drive_case(1, 10, 115, 100, 40, 20, 120, 40, 20, 140, 40, 20);
        run_check("floor115", 0);
        drive_case(1, 10, 50, 10, 50, 0, 120, 40, 20, 140, 40, 20);
        run_check("h0", 0);

        drive_case(1, 250, 50, 2, 50, 6, 120, 40, 20, 140, 40, 20);
        run_check("wrap_miss", 0);
        drive_case(1, 250, 50, 253, 50, 6, 120, 40, 20, 140, 40, 20);
        run_check("wrap_hit", 0);

        // A at top-left, B touching right/bottom corner, C one pixel left of heli.
        drive_case(1, 10, 0, 10, 0, 1, 17, 5, 1, 4, 0, 1);
        run_check("multi", 3);

        // Abort in CMP_B after an A hit.
        drive_case(0, 10, 50, 12, 52, 3, 120, 40, 20, 140, 40, 20);
        bus.check = 1'b1;
        tick();
        tick();
        chk("abort A_set", 32'(bus.hit_flags), 32'h1);
        bus.check = 1'b0;
        tick();
        chk("abort flags", 32'(bus.hit_flags), 32'd0);
        chk("abort coll", 32'(bus.collision), 32'd0);
        chk("abort done", 32'(bus.doneCheck), 32'd0);
        tick();
        chk("abort done2", 32'(bus.doneCheck), 32'd0);

        // Reset in CMP_C after an A hit.
        bus.check = 1'b1;
        tick();
        tick();
        tick();
        chk("rstC A_set", 32'(bus.collision), 32'd1);
        reset = 1'b1;
        tick();
        chk("rstC flags", 32'(bus.hit_flags), 32'd0);
        chk("rstC coll", 32'(bus.collision), 32'd0);
        chk("rstC done", 32'(bus.doneCheck), 32'd0);
        reset = 1'b0;
        bus.check = 1'b0;
        tick();

        drive_case(1, 10, 50, 12, 52, 3, 120, 40, 20, 140, 40, 20);
        run_check("after_rst", 0);
        drive_case(1, 10, 50, 100, 40, 20, 120, 40, 20, 140, 40, 20);
        run_check("clear_next", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
